m2vside1: RTL
=============

# m2vside1

First-stage side-information container of the MPEG2 video decoder. It accepts one macroblock descriptor per handshake from the macroblock header parser: motion vector, position, intra flag and coded_block_pattern. Descriptors are buffered in a 2-entry FIFO. Each descriptor is expanded into six per-block side-information words (blocks 0..5, 4:2:0). Stage 2 latches the current word on every block_start pulse from m2vctrl, and the same pulse advances this block to the next word.

## Interface

Parameters:
- MVH_WIDTH, 16, horizontal motion vector width
- MVV_WIDTH, 15, vertical motion vector width
- MBX_WIDTH, 6, macroblock column width
- MBY_WIDTH, 5, macroblock row width

Ports:
- clk  input  1  single clock for the whole block
- reset_n  input  1  reset, asynchronous, active-low
- hdr_valid  input  1  descriptor on hdr_* is valid
- hdr_ready  output  1  FIFO can accept a descriptor this cycle
- hdr_mv_h  input  MVH_WIDTH  horizontal motion vector
- hdr_mv_v  input  MVV_WIDTH  vertical motion vector
- hdr_mb_x  input  MBX_WIDTH  macroblock column
- hdr_mb_y  input  MBY_WIDTH  macroblock row
- hdr_mb_intra  input  1  intra macroblock
- hdr_cbp  input  6  coded_block_pattern; bit 5 = block 0 … bit 0 = block 5
- pic_start  input  1  synchronous flush pulse from m2vctrl at picture start
- block_start  input  1  block start pulse from m2vctrl (the same pulse that latches stage 2)
- s1_mv_h  output  MVH_WIDTH  current block motion vector, horizontal
- s1_mv_v  output  MVV_WIDTH  current block motion vector, vertical
- s1_mb_x  output  MBX_WIDTH  current macroblock column
- s1_mb_y  output  MBY_WIDTH  current macroblock row
- s1_mb_intra  output  1  current macroblock is intra
- s1_block  output  3  current block index, 0..5
- s1_coded  output  1  current block carries coefficients
- s1_enable  output  1  s1_* describes a real block; 0 = bubble

## Operation

- A descriptor is accepted on a clock edge where hdr_valid=1 and hdr_ready=1.
- hdr_ready = (FIFO count < 2). It is a registered-count decode, not combinationally dependent on block_start.
- FIFO entry contents: mv_h, mv_v, mb_x, mb_y, mb_intra, cbp.
- Current slot: one descriptor plus a 3-bit block counter. s1_enable=1 when the slot is occupied.
- s1_coded = slot.mb_intra | slot.cbp[5 - s1_block].
- Slot load: when the slot is empty and the FIFO is non-empty, the FIFO head is popped into the slot with s1_block=0 and s1_enable=1.
- block_start with s1_enable=1 and s1_block<5: s1_block increments; other fields are held.
- block_start with s1_enable=1 and s1_block=5:
  - FIFO non-empty: the head is loaded on the same edge with s1_block=0 (back-to-back macroblocks, no bubble).
  - FIFO empty: s1_enable is cleared.
- block_start with s1_enable=0: no state change; stage 2 captures a bubble.
- When s1_enable=0, the s1 data outputs hold their last values and s1_block holds its value.
- Push and pop in the same cycle are allowed. The count is unchanged and the FIFO stays ordered.
- pic_start: FIFO count goes to 0, slot is emptied, s1_enable=0. A same-cycle push and a same-cycle block_start are ignored. pic_start has priority over all other events.

## Timing

- Reset (asynchronous, while reset_n=0):
  - all s1_* outputs = 0
  - FIFO count = 0, so hdr_ready = 1
- Latency from handshake edge to s1_enable=1, with the slot and FIFO empty: 2 clocks (edge 1 writes the FIFO, edge 2 loads the slot).
- Latency of s1_* after a block_start edge: the new values are visible in the next cycle. Stage 2 captures the pre-edge values on the same edge.
- Throughput: one macroblock per 6 block_start pulses. The FIFO absorbs up to 2 descriptors ahead of the slot, so at most 3 descriptors are held in total.
- Reset asserted mid-macroblock: all state is lost immediately and no stale block is emitted after release.

## Test plan

- Reset, then push one descriptor {mv_h=0x0123, mv_v=0x0456, mb_x=3, mb_y=2, intra=0, cbp=6'b101001} → s1_enable=1 two clocks after the handshake. Over six block_start pulses, s1_block goes 0..5 and s1_coded goes 1,0,1,0,0,1. After the 6th pulse, s1_enable=0.
- Intra descriptor with cbp=0 → s1_coded=1 for all six blocks.
- Push 3 descriptors while no block_start is issued → hdr_ready drops to 0 after the 3rd accept (slot full, FIFO count 2). On the 6th block_start, descriptor 2 loads with no bubble, s1_block=0, and hdr_ready returns to 1 on the next cycle.
- FIFO count 2 with hdr_valid held at 1 and block_start popping → no accept while hdr_ready=0. Check that the order of mb_x values is preserved across 3 macroblocks.
- block_start pulses while idle → s1_enable stays 0 and s1_block does not change.
- pic_start during block 3 with FIFO count 1 and a simultaneous hdr handshake → next cycle s1_enable=0 and hdr_ready=1. No descriptor is emitted until a new push is made.

Source files
------------

// File: rtl/m2vside1_if.sv
// rtl/m2vside1_if.sv - macroblock descriptor handshake bus, parser to side-info container
interface m2vside1_if #(
    parameter int MVH_WIDTH = 16,
    parameter int MVV_WIDTH = 15,
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
) ();
    logic                 hdr_valid;
    logic                 hdr_ready;
    logic [MVH_WIDTH-1:0] hdr_mv_h;
    logic [MVV_WIDTH-1:0] hdr_mv_v;
    logic [MBX_WIDTH-1:0] hdr_mb_x;
    logic [MBY_WIDTH-1:0] hdr_mb_y;
    logic                 hdr_mb_intra;
    logic [5:0]           hdr_cbp;

    modport master (
        output hdr_valid,
        output hdr_mv_h,
        output hdr_mv_v,
        output hdr_mb_x,
        output hdr_mb_y,
        output hdr_mb_intra,
        output hdr_cbp,
        input  hdr_ready
    );

    modport slave (
        input  hdr_valid,
        input  hdr_mv_h,
        input  hdr_mv_v,
        input  hdr_mb_x,
        input  hdr_mb_y,
        input  hdr_mb_intra,
        input  hdr_cbp,
        output hdr_ready
    );
endinterface

// File: rtl/m2vside1.sv
// rtl/m2vside1.sv - MPEG2 decoder stage-1 side-information container
// A 2-deep descriptor FIFO feeds one slot that walks blocks 0..5 on block_start.
module m2vside1 #(
    parameter int MVH_WIDTH = 16,
    parameter int MVV_WIDTH = 15,
    parameter int MBX_WIDTH = 6,
    parameter int MBY_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    m2vside1_if.slave            hdr,
    input  logic                 pic_start,
    input  logic                 block_start,
    output logic [MVH_WIDTH-1:0] s1_mv_h,
    output logic [MVV_WIDTH-1:0] s1_mv_v,
    output logic [MBX_WIDTH-1:0] s1_mb_x,
    output logic [MBY_WIDTH-1:0] s1_mb_y,
    output logic                 s1_mb_intra,
    output logic [2:0]           s1_block,
    output logic                 s1_coded,
    output logic                 s1_enable
);

    typedef struct packed {
        logic [MVH_WIDTH-1:0] mv_h;
        logic [MVV_WIDTH-1:0] mv_v;
        logic [MBX_WIDTH-1:0] mb_x;
        logic [MBY_WIDTH-1:0] mb_y;
        logic                 intra;
        logic [5:0]           cbp;
    } desc_t;

    desc_t      fifo_q [2];
    desc_t      fifo_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    desc_t      slot_q, slot_d;
    logic [2:0] block_q, block_d;
    logic       enable_q, enable_d;

    desc_t      hdr_desc;
    logic       ready;
    logic       push;
    logic       pop;
    logic       last_block;

    assign hdr_desc = '{
        mv_h:  hdr.hdr_mv_h,
        mv_v:  hdr.hdr_mv_v,
        mb_x:  hdr.hdr_mb_x,
        mb_y:  hdr.hdr_mb_y,
        intra: hdr.hdr_mb_intra,
        cbp:   hdr.hdr_cbp
    };

    // Ready decodes only the registered count, never block_start.
    assign ready         = (count_q < 2'd2);
    assign hdr.hdr_ready = ready;
    assign push          = hdr.hdr_valid && ready;
    assign last_block    = (block_q == 3'd5);
    // Refill an empty slot at once, or swap in the next macroblock as block 5 retires.
    assign pop           = (count_q != 2'd0) && (!enable_q || (block_start && last_block));

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        slot_d   = slot_q;
        block_d  = block_q;
        enable_d = enable_q;

        if (pic_start) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
            enable_d = 1'b0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = hdr_desc;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                slot_d   = fifo_q[rd_ptr_q];
                rd_ptr_d = ~rd_ptr_q;
                block_d  = 3'd0;
                enable_d = 1'b1;
            end else if (enable_q && block_start) begin
                if (last_block) begin
                    enable_d = 1'b0;
                end else begin
                    block_d = block_q + 3'd1;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            slot_q    <= '0;
            block_q   <= 3'd0;
            enable_q  <= 1'b0;
        end else begin
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            slot_q    <= slot_d;
            block_q   <= block_d;
            enable_q  <= enable_d;
        end
    end

    assign s1_mv_h     = slot_q.mv_h;
    assign s1_mv_v     = slot_q.mv_v;
    assign s1_mb_x     = slot_q.mb_x;
    assign s1_mb_y     = slot_q.mb_y;
    assign s1_mb_intra = slot_q.intra;
    assign s1_block    = block_q;
    assign s1_enable   = enable_q;
    // cbp is MSB-first: bit 5 belongs to block 0.
    assign s1_coded    = slot_q.intra | slot_q.cbp[3'd5 - block_q];

endmodule
